// File: rtl/lstm_seq_driver_if.sv
// Handshake and data bundle between the LSTM sequence driver and its
// neighbours: upstream sample stream, the LSTM cell, and the final-h result.
// The master modport is the driver's view; the slave modport is the view of
// everything around it (stream source, cell, result sink).
interface lstm_seq_driver_if #(
  parameter int WIDTH = 16
);

  // Upstream sequence samples
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             s_last;

  // Cell input side: sample plus recurrent state
  logic [WIDTH-1:0] x_in;
  logic             x_valid;
  logic             x_ready;
  logic [WIDTH-1:0] h_in;
  logic [WIDTH-1:0] C_in;

  // Cell output side
  logic [WIDTH-1:0] y_out;
  logic [WIDTH-1:0] C_out;
  logic             y_valid;

  // Final hidden state of a sequence
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  s_data, s_valid, s_last,
    output s_ready,
    output x_in, x_valid, h_in, C_in,
    input  x_ready,
    input  y_out, C_out, y_valid,
    output m_data, m_valid,
    input  m_ready
  );

  modport slave (
    output s_data, s_valid, s_last,
    input  s_ready,
    input  x_in, x_valid, h_in, C_in,
    output x_ready,
    output y_out, C_out, y_valid,
    input  m_data, m_valid,
    output m_ready
  );

endinterface

// File: rtl/lstm_seq_driver.sv
// LSTM sequence driver.
// Walks one sequence of samples through an external LSTM cell, one step at a
// time: accept a sample, present it to the cell together with the recurrent
// hidden/cell state, wait for the cell's answer, and fold that answer back in
// as the state for the next step. After the sample flagged last, the final
// hidden state is offered on the result handshake; accepting it clears the
// recurrent state so the next sequence starts from h = C = 0.
//
// Data is never modified: samples, h and C are two's-complement values that
// pass through bit-exact.
//
// Optional build macro LSTM_SEQ_TIMEOUT_EN: adds a WAIT watchdog. 256
// consecutive WAIT cycles without a cell answer set the sticky timeout_err
// output and force the result phase with the current hidden state.
module lstm_seq_driver #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  lstm_seq_driver_if.master bus,
  output logic [CNT_W-1:0]  step_count,
  output logic              busy
`ifdef LSTM_SEQ_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   h_q, h_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef LSTM_SEQ_TIMEOUT_EN
  logic [7:0]         wait_q, wait_d;
  logic               tmo_q, tmo_d;
`endif

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (rst) begin
      // NOTE: every register here is a plain flop (no memory arrays), so all
      // of them are reset; outputs derived from them then come up at zero.
      state_q <= ST_LOAD;
      x_q     <= '0;
      last_q  <= 1'b0;
      h_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
`ifdef LSTM_SEQ_TIMEOUT_EN
      wait_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      last_q  <= last_d;
      h_q     <= h_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
`ifdef LSTM_SEQ_TIMEOUT_EN
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    state_d     = state_q;
    x_d         = x_q;
    last_d      = last_q;
    h_d         = h_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
`ifdef LSTM_SEQ_TIMEOUT_EN
    wait_d      = '0;
    tmo_d       = tmo_q;
`endif
    bus.s_ready = 1'b0;
    bus.x_valid = 1'b0;
    bus.m_valid = 1'b0;
    busy        = 1'b1;

    unique case (state_q)
      ST_LOAD: begin
        bus.s_ready = 1'b1;
        busy        = 1'b0;
        if (bus.s_valid) begin
          x_d     = bus.s_data;
          last_d  = bus.s_last;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        bus.x_valid = 1'b1;
        if (bus.x_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A cell answer is only meaningful here; anywhere else it is dropped.
        if (bus.y_valid) begin
          h_d     = bus.y_out;
          c_d     = bus.C_out;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = last_q ? ST_DONE : ST_LOAD;
        end
`ifdef LSTM_SEQ_TIMEOUT_EN
        // wait_q counts WAIT cycles already spent; 255 means this is the 256th.
        else if (wait_q == 8'hFF) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
`endif
      end

      ST_DONE: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) begin
          h_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Registered values shown directly; h/C feed the cell continuously
  assign bus.x_in   = x_q;
  assign bus.h_in   = h_q;
  assign bus.C_in   = c_q;
  assign bus.m_data = h_q;
  assign step_count = cnt_q;
`ifdef LSTM_SEQ_TIMEOUT_EN
  assign timeout_err = tmo_q;
`endif

endmodule

// File: tb/tb_lstm_seq_driver.sv
// Testbench for lstm_seq_driver.
// A transaction-level model (expected h, C, step count and current sample)
// is updated by the stimulus tasks whenever a step or result is accepted; a
// compare process checks the DUT against it on every falling edge. Directed
// literal checks pin the model at key points.
// Build with LSTM_SEQ_TIMEOUT_EN defined to also exercise the watchdog.
module tb_lstm_seq_driver;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lstm_seq_driver_if #(.WIDTH(WIDTH)) bus ();
  logic [CNT_W-1:0] step_count;
  logic             busy;
`ifdef LSTM_SEQ_TIMEOUT_EN
  logic             timeout_err;
`endif

  lstm_seq_driver #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .step_count (step_count),
    .busy       (busy)
`ifdef LSTM_SEQ_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  // Reference model state
  logic [WIDTH-1:0] model_h, model_c, model_x;
  int               model_cnt;
  bit               chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    model_h   = '0;
    model_c   = '0;
    model_cnt = 0;
  endtask

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("h_in", bus.h_in, model_h);
      check("C_in", bus.C_in, model_c);
      check("step_count", step_count, model_cnt);
      check("busy_vs_s_ready", busy, !bus.s_ready);
      if (bus.x_valid) check("x_in", bus.x_in, model_x);
      if (bus.m_valid) check("m_data", bus.m_data, model_h);
    end
  end

  task automatic reset_checks();
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_x_valid", bus.x_valid, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_x_in", bus.x_in, 0);
    check("rst_h_in", bus.h_in, 0);
    check("rst_C_in", bus.C_in, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_step_count", step_count, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    model_x = '0;
  endtask

  task automatic send_sample(input logic [WIDTH-1:0] d, input bit last);
    int n = 0;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.s_ready) begin
      check("s_ready_wait", bus.s_ready, 1);
    end else begin
      tick();
      model_x = d;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic issue_step(input int stall);
    int n = 0;
    while (!bus.x_valid && n < 20) begin
      tick();
      n++;
    end
    check("x_valid_wait", bus.x_valid, 1);
    for (int i = 0; i < stall; i++) begin
      check("stall_x_valid", bus.x_valid, 1);
      check("stall_s_ready", bus.s_ready, 0);
      tick();
    end
    bus.x_ready = 1'b1;
    tick();
    bus.x_ready = 1'b0;
    check("x_valid_drop", bus.x_valid, 0);
  endtask

  task automatic respond(input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] c, input int delay);
    repeat (delay) tick();
    bus.y_valid = 1'b1;
    bus.y_out   = y;
    bus.C_out   = c;
    tick();
    bus.y_valid = 1'b0;
    model_h = y;
    model_c = c;
    if (model_cnt < CNT_MAX) model_cnt++;
  endtask

  // Cell strobe outside WAIT: the model must not move
  task automatic noise_y();
    bus.y_valid = 1'b1;
    bus.y_out   = WIDTH'($urandom);
    bus.C_out   = WIDTH'($urandom);
    tick();
    bus.y_valid = 1'b0;
  endtask

  task automatic accept(input int stall);
    int n = 0;
    while (!bus.m_valid && n < 400) begin
      tick();
      n++;
    end
    check("m_valid_wait", bus.m_valid, 1);
    for (int i = 0; i < stall; i++) begin
      check("hold_m_valid", bus.m_valid, 1);
      tick();
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    model_clear();
    check("m_valid_drop", bus.m_valid, 0);
    check("s_ready_after_done", bus.s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.x_ready = 1'b0;
    bus.y_out   = '0;
    bus.C_out   = '0;
    bus.y_valid = 1'b0;
    bus.m_ready = 1'b0;
    model_clear();
    model_x = '0;
    tick();
    tick();
    rst = 1'b0;
    reset_checks();
    chk_en = 1'b1;

    // Three-step sequence, minimum latency
    send_sample(16'h0100, 1'b0);
    check("seq1_h_in_step1", bus.h_in, 16'h0000);
    issue_step(0);
    respond(16'h0011, 16'h00A1, 0);
    send_sample(16'h0200, 1'b0);
    check("seq1_h_in_step2", bus.h_in, 16'h0011);
    check("seq1_C_in_step2", bus.C_in, 16'h00A1);
    issue_step(0);
    respond(16'h0022, 16'h00A2, 0);
    send_sample(16'h0300, 1'b1);
    check("seq1_h_in_step3", bus.h_in, 16'h0022);
    issue_step(0);
    respond(16'h0033, 16'h00A3, 0);
    check("seq1_m_valid", bus.m_valid, 1);
    check("seq1_m_data", bus.m_data, 16'h0033);
    check("seq1_step_count", step_count, 3);
    // Stray cell strobes in DONE, then a stalled result accept
    noise_y();
    noise_y();
    check("done_noise_m_data", bus.m_data, 16'h0033);
    accept(4);
    check("seq1_cleared_h", bus.h_in, 16'h0000);

    // Stray strobes in LOAD, stalled ISSUE, delayed cell answer
    noise_y();
    noise_y();
    check("load_noise_h", bus.h_in, 16'h0000);
    send_sample(16'h1234, 1'b0);
    issue_step(5);
    respond(16'h7FFF, 16'h8000, 3);
    send_sample(16'hFFFF, 1'b1);
    check("seq2_h_in_step2", bus.h_in, 16'h7FFF);
    check("seq2_C_in_step2", bus.C_in, 16'h8000);
    issue_step(0);
    respond(16'h8001, 16'h0001, 0);
    accept(0);

    // Single-sample sequence starts from zero state
    send_sample(16'h0042, 1'b1);
    check("seq3_h_in_first", bus.h_in, 16'h0000);
    check("seq3_C_in_first", bus.C_in, 16'h0000);
    issue_step(0);
    respond(16'h5A5A, 16'hA5A5, 1);
    check("seq3_m_data", bus.m_data, 16'h5A5A);
    check("seq3_step_count", step_count, 1);
    accept(0);

    // Reset during WAIT of step 2; late cell answer is ignored
    send_sample(16'h0100, 1'b0);
    issue_step(0);
    respond(16'h0011, 16'h00B1, 0);
    send_sample(16'h0200, 1'b0);
    issue_step(0);
    do_reset();
    reset_checks();
    noise_y();
    noise_y();
    check("late_y_h_in", bus.h_in, 16'h0000);
    check("late_y_step_count", step_count, 0);
    check("late_y_s_ready", bus.s_ready, 1);
    send_sample(16'h0777, 1'b1);
    issue_step(0);
    respond(16'h0123, 16'h0456, 0);
    check("post_rst_m_data", bus.m_data, 16'h0123);
    accept(0);

    // Long sequence: step counter saturates without wrapping
    for (int i = 0; i < 258; i++) begin
      send_sample(WIDTH'(i), i == 257);
      issue_step(0);
      respond(WIDTH'(i + 1), ~WIDTH'(i), 0);
    end
    check("sat_step_count", step_count, 8'hFF);
    check("sat_m_data", bus.m_data, 16'h0102);
    accept(0);

`ifdef LSTM_SEQ_TIMEOUT_EN
    // Cell never answers step 2: watchdog forces DONE after 256 WAIT cycles
    begin
      int n = 0;
      check("tmo_initial", timeout_err, 0);
      send_sample(16'h0900, 1'b0);
      issue_step(0);
      respond(16'h1357, 16'h2468, 0);
      send_sample(16'h0901, 1'b0);
      issue_step(0);
      while (!bus.m_valid && n < 300) begin
        tick();
        n++;
      end
      check("tmo_cycles", n, 256);
      check("tmo_err_set", timeout_err, 1);
      check("tmo_m_valid", bus.m_valid, 1);
      check("tmo_m_data", bus.m_data, 16'h1357);
      check("tmo_step_count", step_count, 1);
      accept(0);
      check("tmo_sticky_1", timeout_err, 1);
      send_sample(16'h0A00, 1'b1);
      issue_step(0);
      respond(16'h0B00, 16'h0C00, 0);
      accept(0);
      check("tmo_sticky_2", timeout_err, 1);
      do_reset();
      check("tmo_cleared", timeout_err, 0);
    end
`endif

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lstm_seq_driver.md
LSTM_SEQ_DRIVER -- requirements
Module: lstm_seq_driver

Interface
REQ-001 Parameter WIDTH, default 16, signed two's-complement width of samples, h and C.
REQ-002 Parameter CNT_W, default 8, width of step counter.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_data  input  WIDTH  upstream sequence sample.
REQ-006 s_valid / s_ready  input / output  1  upstream handshake; transfer when both high.
REQ-007 s_last  input  1  marks final sample of a sequence; sampled with s_data.
REQ-008 x_in  output  WIDTH  sample driven to LSTM cell.
REQ-009 x_valid / x_ready  output / input  1  cell input handshake.
REQ-010 h_in, C_in  output  WIDTH each  recurrent hidden/cell state driven to cell.
REQ-011 y_out, C_out  input  WIDTH each  new h and C returned by cell.
REQ-012 y_valid  input  1  single-cycle strobe qualifying y_out and C_out.
REQ-013 m_data / m_valid / m_ready  output / output / input  WIDTH/1/1  final-h result handshake.
REQ-014 step_count  output  CNT_W  steps completed in current sequence.
REQ-015 busy  output  1  high in any state except LOAD.

Function
REQ-016 FSM states: LOAD, ISSUE, WAIT, DONE.
REQ-017 LOAD: s_ready=1; on s_valid&&s_ready capture s_data into x register and s_last into last flag, go to ISSUE next cycle.
REQ-018 ISSUE: x_valid=1, x_in=captured sample stable; on x_ready go to WAIT; x_valid deasserts same edge.
REQ-019 WAIT: on y_valid load h_reg<=y_out, C_reg<=C_out, step_count+1; then DONE if last flag set, else LOAD.
REQ-020 y_valid in any state other than WAIT is ignored; h_reg, C_reg, step_count unchanged.
REQ-021 h_in=h_reg, C_in=C_reg combinationally at all times; both zero for first step of every sequence.
REQ-022 DONE: m_valid=1, m_data=h_reg stable until m_ready; on m_valid&&m_ready clear h_reg, C_reg, step_count to 0 and go to LOAD.
REQ-023 step_count saturates at 2^CNT_W-1; no wrap; sequence continues normally.
REQ-024 s_ready=0 outside LOAD; a single-sample sequence (s_last on first sample) takes LOAD->ISSUE->WAIT->DONE.
REQ-025 Minimum per-step latency: 1 cycle LOAD, 1 cycle ISSUE (x_ready already high), 1 cycle WAIT (y_valid next cycle) = 3 cycles.
REQ-026 No arithmetic on data; values pass bit-exact.

Reset
REQ-027 On rst: state=LOAD, h_reg=C_reg=x register=0, last flag=0, step_count=0.
REQ-028 Reset outputs: s_ready=1, x_valid=0, m_valid=0, busy=0, x_in=h_in=C_in=m_data=0.
REQ-029 rst mid-sequence aborts it; any later y_valid for the aborted step is ignored (REQ-020).

Configuration
REQ-030 Macro LSTM_SEQ_TIMEOUT_EN defined: add output timeout_err (1 bit) and 8-bit WAIT counter; 256 consecutive WAIT cycles without y_valid set timeout_err sticky (cleared only by rst) and force DONE with m_data=current h_reg.
REQ-031 Macro undefined: no timeout_err port, no counter; WAIT holds indefinitely.

Verification
REQ-032 Reset, then sequence 3 samples (0x0100,0x0200,0x0300 last), cell returns y_out=0x0011,0x0022,0x0033 -> h_in 0,0x0011,0x0022 per step; m_data=0x0033, step_count=3.
REQ-033 x_ready held low 5 cycles in ISSUE -> x_valid high and x_in constant throughout; no s_ready.
REQ-034 y_valid pulsed during LOAD and DONE -> h_reg/C_reg/step_count unchanged.
REQ-035 m_ready low 4 cycles in DONE -> m_data stable; after accept, next sequence first step shows h_in=C_in=0.
REQ-036 rst asserted in WAIT of step 2 -> all outputs at reset values next cycle; late y_valid ignored.
REQ-037 With LSTM_SEQ_TIMEOUT_EN, no y_valid for 256 cycles -> timeout_err=1, m_valid=1, m_data=last h_reg; timeout_err stays 1 until rst.
